// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spu_pkg
//  Brief    : Shared widths, NOP encoding and fetch-queue entry type for SPU IF
//  Revision : 1.0  initial release
// ============================================================================
package spu_pkg;

    localparam int PC_BITS = 11;
    localparam int INSTR_W = 32;
    localparam int QDEPTH  = 2;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h4020_0000;

    typedef struct packed {
        logic [PC_BITS-1:0] pc;
        logic [INSTR_W-1:0] even;
        logic [INSTR_W-1:0] odd;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Brief    : 2-entry FIFO of fetched instruction pairs; head is the IF/ID view
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue
    import spu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t push_data_i,
    output logic [1:0]   count_o,
    output logic         head_valid_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [QDEPTH];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_pop;
    logic         do_push;

    // Single-bit pointers: the depth is fixed at two entries.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !reset) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_o       = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_unit
//  Brief    : SPU IF stage - PC, credit-gated 8-byte fetch, redirect and squash
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_unit
    import spu_pkg::*;
#(
    parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [PC_BITS-1:0]   imem_addr,
    input  logic [2*INSTR_W-1:0] imem_rdata,
    input  logic                 stall,
    input  logic                 branch_result,
    input  logic [PC_BITS-1:0]   branch_address,
    output logic                 fetch_valid,
    output logic [INSTR_W-1:0]   instruction_even,
    output logic [INSTR_W-1:0]   instruction_odd,
    output logic [PC_BITS-1:0]   pc_out,
    output logic [PC_BITS-1:0]   pcpluseight_out
);

    fetch_state_e       state_q, state_d;
    logic [PC_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic               infl_q;
    logic [PC_BITS-1:0] infl_pc_q;
    logic               infl_epoch_q;
    logic               epoch_q;

    logic [1:0]         q_count;
    logic               head_valid;
    fetch_entry_t       head;
    fetch_entry_t       resp_entry;
    logic               pop;
    logic               push;
    logic               req;
    logic [2:0]         occupancy;
    logic [2:0]         unused_addr_bits;

    assign unused_addr_bits = branch_address[2:0];

    // Queued pairs plus the one in flight must leave room for a new response.
    assign pop       = head_valid && !stall;
    assign occupancy = {1'b0, q_count} + {2'b00, infl_q};
    assign req       = (state_q == ST_FETCH) && !reset && !branch_result
                       && (occupancy < (3'd2 + {2'b00, pop}));

    // Responses tagged with a superseded epoch, or landing in a redirect cycle, are squashed.
    assign push = infl_q && (infl_epoch_q == epoch_q) && !branch_result;

    assign resp_entry = '{pc:   infl_pc_q,
                          even: imem_rdata[2*INSTR_W-1:INSTR_W],
                          odd:  imem_rdata[INSTR_W-1:0]};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
        if (branch_result) begin
            fetch_pc_d = {branch_address[PC_BITS-1:3], 3'b000};
        end else if (req) begin
            fetch_pc_d = fetch_pc_q + PC_BITS'(8);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            infl_q       <= 1'b0;
            infl_pc_q    <= '0;
            infl_epoch_q <= 1'b0;
            epoch_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            infl_q     <= req;
            if (req) begin
                infl_pc_q    <= fetch_pc_q;
                infl_epoch_q <= epoch_q;
            end
            if (branch_result) begin
                epoch_q <= ~epoch_q;
            end
        end
    end

    fetch_queue u_fetch_queue (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (branch_result),
        .push_i       (push),
        .pop_i        (pop),
        .push_data_i  (resp_entry),
        .count_o      (q_count),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    assign imem_req         = req;
    assign imem_addr        = fetch_pc_q;
    assign fetch_valid      = head_valid;
    assign instruction_even = head_valid ? head.even : NOP_INSTR;
    assign instruction_odd  = head_valid ? head.odd  : NOP_INSTR;
    assign pc_out           = head_valid ? head.pc   : '0;
    assign pcpluseight_out  = pc_out + PC_BITS'(8);

endmodule
`default_nettype wire
